// File: rtl/cfg_bitfile_loader_pkg.sv
// Shared definitions for the configuration bitfile loader: FSM state encoding and
// the bitfile geometry as seen by the Controller.
package cfg_pkg;

    localparam int unsigned CFG_WIDTH_DEFAULT = 8;
    localparam int unsigned CTRL_SIG_W        = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } cfg_state_e;

    // Even parity over data plus parity bit holds when the XOR of all bits is zero.
    function automatic logic parity_ok(input logic running_xor);
        return ~running_xor;
    endfunction

endpackage

// File: rtl/cfg_bitfile_loader_if.sv
// Serial configuration port: start/abort control plus a valid/ready bit stream.
interface cfg_bitfile_loader_if;

    logic cfg_start;
    logic cfg_abort;
    logic cfg_bit;
    logic cfg_valid;
    logic cfg_ready;

    modport master (
        output cfg_start,
        output cfg_abort,
        output cfg_bit,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_start,
        input  cfg_abort,
        input  cfg_bit,
        input  cfg_valid,
        output cfg_ready
    );

endinterface

// File: rtl/cfg_bitfile_loader_shift_reg.sv
// Shadow register, beat counter and running parity for one serial bitfile load.
module cfg_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         beat_i,
    input  logic                         bit_i,
    output logic [WIDTH-1:0]             shadow_o,
    output logic [$clog2(WIDTH+1)-1:0]   cnt_o,
    output logic                         par_o,
    output logic                         last_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    logic [WIDTH-1:0] shadow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
        end else if (clear_i) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
        end else if (beat_i) begin
            // The parity beat (cnt == WIDTH) only folds into the running XOR.
            par_q <= par_q ^ bit_i;
            if (cnt_q != LAST_CNT) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        shadow_q[i] <= bit_i;
                    end
                end
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign shadow_o = shadow_q;
    assign cnt_o    = cnt_q;
    assign par_o    = par_q;
    assign last_o   = (cnt_q == LAST_CNT);

endmodule

// File: rtl/cfg_bitfile_loader.sv
// Serial bitfile loader: shifts bits into a shadow register, checks even parity and
// commits the whole bitfile to the Controller in a single cycle.
module cfg_bitfile_loader
    import cfg_pkg::*;
#(
    parameter int unsigned          CFG_WIDTH = CFG_WIDTH_DEFAULT,
    parameter logic [CFG_WIDTH-1:0] RESET_CFG = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    cfg_bitfile_loader_if.slave  cfg_if,
    output logic [CFG_WIDTH-1:0] bitfile,
    output logic                 busy,
    output logic                 cfg_done,
    output logic                 cfg_err
);

    localparam int unsigned CNT_W = $clog2(CFG_WIDTH + 1);

    cfg_state_e           state_q;
    logic [CFG_WIDTH-1:0] bitfile_q;
    logic                 done_q;
    logic                 err_q;

    logic [CFG_WIDTH-1:0] shadow;
    logic [CNT_W-1:0]     cnt;
    logic                 par;
    logic                 last;
    logic                 in_idle;
    logic                 in_shift;
    logic                 beat;
    logic                 start_ok;
    logic                 clear;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_shift = (state_q == ST_SHIFT);
    assign start_ok = in_idle & cfg_if.cfg_start & ~cfg_if.cfg_abort;
    // Abort outranks a beat presented in the same cycle.
    assign beat     = in_shift & cfg_if.cfg_valid & ~cfg_if.cfg_abort;
    assign clear    = start_ok | (in_shift & cfg_if.cfg_abort);

    cfg_shift_reg #(
        .WIDTH (CFG_WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (clear),
        .beat_i   (beat),
        .bit_i    (cfg_if.cfg_bit),
        .shadow_o (shadow),
        .cnt_o    (cnt),
        .par_o    (par),
        .last_o   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bitfile_q <= RESET_CFG;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_q <= ST_SHIFT;
                        err_q   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cfg_if.cfg_abort) begin
                        state_q <= ST_IDLE;
                    end else if (beat && last) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state_q <= ST_IDLE;
                    if (parity_ok(par)) begin
                        bitfile_q <= shadow;
                        done_q    <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_if.cfg_ready = in_shift;
    assign bitfile          = bitfile_q;
    assign busy             = ~in_idle;
    assign cfg_done         = done_q;
    assign cfg_err          = err_q;

endmodule

// File: tb/tb_cfg_bitfile_loader.sv
// Directed and randomized bench for cfg_bitfile_loader against a parity/commit model.
module tb_cfg_bitfile_loader;

    localparam logic [7:0] RST_VAL = 8'h5A;

    logic       clk;
    logic       rst;
    logic [7:0] bitfile;
    logic       busy;
    logic       cfg_done;
    logic       cfg_err;

    cfg_bitfile_loader_if ifc ();

    cfg_bitfile_loader #(
        .CFG_WIDTH (8),
        .RESET_CFG (RST_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_if   (ifc),
        .bitfile  (bitfile),
        .busy     (busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned acc_beats = 0;
    logic [7:0]  model_bf;
    logic        model_err;

    always @(posedge clk) begin
        if (ifc.cfg_valid && ifc.cfg_ready) acc_beats++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic b);
        int unsigned n = 0;
        ifc.cfg_valid = 1'b1;
        ifc.cfg_bit   = b;
        while (!ifc.cfg_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", {31'b0, ifc.cfg_ready}, 32'd1);
        tick();
        ifc.cfg_valid = 1'b0;
    endtask

    // Full load: optional random gaps, an ignored start pulse after beat stray_at,
    // and an abort held during the check cycle when abort_chk is set.
    task automatic load(input logic [7:0] w, input logic p, input int unsigned maxgap,
                        input int stray_at, input bit abort_chk);
        bit ok;
        ok = ((($countones(w) + int'(p)) % 2) == 0);
        ifc.cfg_start = 1'b1;
        tick();
        ifc.cfg_start = 1'b0;
        check("start_busy", {31'b0, busy}, 32'd1);
        check("start_err_clr", {31'b0, cfg_err}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            send_beat(w[i]);
            if (i == stray_at) begin
                ifc.cfg_start = 1'b1;
                tick();
                ifc.cfg_start = 1'b0;
            end
            if (maxgap != 0) repeat ($urandom_range(maxgap, 0)) tick();
        end
        send_beat(p);
        check("check_ready_low", {31'b0, ifc.cfg_ready}, 32'd0);
        check("done_not_early", {31'b0, cfg_done}, 32'd0);
        check("bitfile_not_early", {24'b0, bitfile}, {24'b0, model_bf});
        if (abort_chk) ifc.cfg_abort = 1'b1;
        tick();
        ifc.cfg_abort = 1'b0;
        if (ok) model_bf = w;
        model_err = !ok;
        check("done", {31'b0, cfg_done}, {31'b0, ok});
        check("bitfile", {24'b0, bitfile}, {24'b0, model_bf});
        check("err", {31'b0, cfg_err}, {31'b0, model_err});
        tick();
        check("done_one_cycle", {31'b0, cfg_done}, 32'd0);
        check("idle_after", {31'b0, busy}, 32'd0);
        check("bitfile_hold", {24'b0, bitfile}, {24'b0, model_bf});
    endtask

    initial begin
        logic [7:0] rw;
        logic       rp;
        rst = 1'b1;
        ifc.cfg_start = 1'b0;
        ifc.cfg_abort = 1'b0;
        ifc.cfg_bit   = 1'b0;
        ifc.cfg_valid = 1'b0;
        model_bf  = RST_VAL;
        model_err = 1'b0;
        #12;
        check("rst_bitfile", {24'b0, bitfile}, {24'b0, RST_VAL});
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ready", {31'b0, ifc.cfg_ready}, 32'd0);
        check("rst_done", {31'b0, cfg_done}, 32'd0);
        check("rst_err", {31'b0, cfg_err}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: good load of 0x9C and Controller field decode
        load(8'h9C, 1'b0, 0, -1, 1'b0);
        check("cs1", {30'b0, bitfile[1:0]}, 32'd0);
        check("cs2", {30'b0, bitfile[3:2]}, 32'd3);
        check("cs3", {30'b0, bitfile[5:4]}, 32'd1);
        check("cs4", {30'b0, bitfile[7:6]}, 32'd2);

        // 2: bad parity keeps bitfile, then a good load clears the error
        load(8'h9C, 1'b1, 0, -1, 1'b0);
        check("err_sticky", {31'b0, cfg_err}, 32'd1);
        load(8'h3F, 1'b0, 0, -1, 1'b0);

        // 3: random valid gaps, exactly 9 beats accepted
        acc_beats = 0;
        load(8'hA5, 1'b0, 5, -1, 1'b0);
        check("beat_count", acc_beats, 32'd9);

        // start and abort together in IDLE: abort wins
        ifc.cfg_start = 1'b1;
        ifc.cfg_abort = 1'b1;
        tick();
        ifc.cfg_start = 1'b0;
        ifc.cfg_abort = 1'b0;
        check("start_abort_idle", {31'b0, busy}, 32'd0);

        // 4: abort after 3 beats (abort beats a simultaneous valid beat)
        ifc.cfg_start = 1'b1;
        tick();
        ifc.cfg_start = 1'b0;
        send_beat(1'b1);
        send_beat(1'b0);
        send_beat(1'b1);
        ifc.cfg_abort = 1'b1;
        ifc.cfg_valid = 1'b1;
        ifc.cfg_bit   = 1'b1;
        tick();
        ifc.cfg_abort = 1'b0;
        ifc.cfg_valid = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_ready", {31'b0, ifc.cfg_ready}, 32'd0);
        check("abort_err", {31'b0, cfg_err}, 32'd0);
        check("abort_bitfile", {24'b0, bitfile}, {24'b0, model_bf});
        tick();
        check("abort_no_done", {31'b0, cfg_done}, 32'd0);
        // start pulsed mid-load is ignored; abort in CHECK is ignored
        load(8'h6E, 1'b1, 0, 3, 1'b1);

        // 5: asynchronous reset after 5 beats
        ifc.cfg_start = 1'b1;
        tick();
        ifc.cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_bf  = RST_VAL;
        model_err = 1'b0;
        check("arst_bitfile", {24'b0, bitfile}, {24'b0, RST_VAL});
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_ready", {31'b0, ifc.cfg_ready}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        load(8'h01, 1'b1, 0, -1, 1'b0);

        // random loads with random parity correctness
        for (int k = 0; k < 12; k++) begin
            rw = 8'($urandom);
            rp = 1'($urandom);
            load(rw, rp, 3, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
